// File: rtl/alu_share_ctrl_pkg.sv
// Shared types for the ALU sharing controller: opcode encodings, FSM states,
// and the combinational ALU used by the top-level result mux.
package alu_share_ctrl_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [3:0] {
    ALU_OP_ADD     = 4'h0,
    ALU_OP_SUB     = 4'h1,
    ALU_OP_AND     = 4'h2,
    ALU_OP_OR      = 4'h3,
    ALU_OP_XOR     = 4'h4,
    ALU_OP_SLL     = 4'h5,
    ALU_OP_SRL     = 4'h6,
    ALU_OP_SLT     = 4'h7,
    ALU_OP_SLTU    = 4'h8,
    ALU_OP_BEQ     = 4'h9,
    ALU_OP_BNE     = 4'hA,
    ALU_OP_BLT     = 4'hB,
    ALU_OP_BGE     = 4'hC,
    ALU_OP_BLTU    = 4'hD,
    ALU_OP_BGEU    = 4'hE,
    ALU_OP_ST_ADDR = 4'hF
  } alu_op_t;

  // Reserved encoding for a wider 5-bit opcode space; unreachable with 4 bits.
  localparam logic [4:0] ALU_OP_RSVD = 5'h10;

  typedef enum logic [1:0] {
    ACTRL_IDLE = 2'd0,
    ACTRL_EXEC = 2'd1,
    ACTRL_RESP = 2'd2
  } actrl_state_t;

  typedef struct packed {
    word_t sum;
    word_t diff;
    word_t and_r;
    word_t or_r;
    word_t xor_r;
    word_t sll;
    word_t srl;
    word_t st_addr;
    logic  eq;
    logic  lt;
    logic  ltu;
  } alu_out_t;

  function automatic alu_out_t alu_compute(input word_t a, input word_t b, input word_t imm);
    alu_out_t r;
    r.sum     = a + b;
    r.diff    = a - b;
    r.and_r   = a & b;
    r.or_r    = a | b;
    r.xor_r   = a ^ b;
    r.sll     = a << b[4:0];
    r.srl     = a >> b[4:0];
    r.st_addr = imm + a;
    r.eq      = (a == b);
    r.lt      = ($signed(a) < $signed(b));
    r.ltu     = (a < b);
    return r;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// One requester port of the ALU sharing controller: request channel plus
// the matching response channel.
interface alu_share_ctrl_if;
  import alu_share_ctrl_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  word_t      req_src1;
  word_t      req_src2;
  word_t      req_imm;
  logic       rsp_valid;
  logic       rsp_ready;
  word_t      rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_src1, req_src2, req_imm, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, req_imm, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl_arb.sv
// Two-way combinational arbiter producing a one-hot grant; round-robin on
// ties when FAIR_RR is set, otherwise port 0 has fixed priority.
module alu_rr_arb2 #(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (FAIR_RR && (valid == 2'b11)) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: grants one request,
// registers its operands, evaluates, and holds the result until consumed.
//
// state | meaning
// IDLE  | waiting for a request; grants one port and captures its operands
// EXEC  | ALU evaluates captured operands; result registered at end of cycle
// RESP  | result presented to the owner port until it is consumed
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_share_ctrl_if.slave        p0,
  alu_share_ctrl_if.slave        p1,
  output logic                   busy
);

  actrl_state_t state, state_nxt;
  logic         last_grant;
  logic         owner;
  logic [1:0]   grant;
  logic         accept;
  logic         owner_rsp_ready;
  alu_op_t      op_q;
  word_t        src1_q, src2_q, imm_q;
  word_t        rsp_data;
  word_t        alu_result;
  alu_out_t     alu_out;

  alu_rr_arb2 #(
    .FAIR_RR (FAIR_RR)
  ) u_arb (
    .valid      ({p1.req_valid, p0.req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Gating with rst keeps requests held through reset from being accepted.
  assign accept          = (state == ACTRL_IDLE) && !rst && (grant != 2'b00);
  assign owner_rsp_ready = owner ? p1.rsp_ready : p0.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACTRL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACTRL_IDLE: if (grant != 2'b00) state_nxt = ACTRL_EXEC;
      ACTRL_EXEC: state_nxt = ACTRL_RESP;
      ACTRL_RESP: if (owner_rsp_ready) state_nxt = ACTRL_IDLE;
      default:    state_nxt = ACTRL_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != ACTRL_IDLE);
    p0.req_ready = accept && grant[0];
    p1.req_ready = accept && grant[1];
    p0.rsp_valid = (state == ACTRL_RESP) && !owner;
    p1.rsp_valid = (state == ACTRL_RESP) && owner;
    p0.rsp_data  = rsp_data;
    p1.rsp_data  = rsp_data;
    p0.rsp_err   = DISABLE;
    p1.rsp_err   = DISABLE;
  end

  assign alu_out = alu_compute(src1_q, src2_q, imm_q);

  always_comb begin
    alu_result = '0;
    case (op_q)
      ALU_OP_ADD:     alu_result = alu_out.sum;
      ALU_OP_SUB:     alu_result = alu_out.diff;
      ALU_OP_AND:     alu_result = alu_out.and_r;
      ALU_OP_OR:      alu_result = alu_out.or_r;
      ALU_OP_XOR:     alu_result = alu_out.xor_r;
      ALU_OP_SLL:     alu_result = alu_out.sll;
      ALU_OP_SRL:     alu_result = alu_out.srl;
      ALU_OP_SLT:     alu_result = {31'd0, alu_out.lt};
      ALU_OP_SLTU:    alu_result = {31'd0, alu_out.ltu};
      ALU_OP_BEQ:     alu_result = {31'd0, alu_out.eq};
      ALU_OP_BNE:     alu_result = {31'd0, !alu_out.eq};
      ALU_OP_BLT:     alu_result = {31'd0, alu_out.lt};
      ALU_OP_BGE:     alu_result = {31'd0, !alu_out.lt};
      ALU_OP_BLTU:    alu_result = {31'd0, alu_out.ltu};
      ALU_OP_BGEU:    alu_result = {31'd0, !alu_out.ltu};
      ALU_OP_ST_ADDR: alu_result = alu_out.st_addr;
      default:        alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= ALU_OP_ADD;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        owner      <= grant[1];
        last_grant <= grant[1];
        if (grant[1]) begin
          op_q   <= alu_op_t'(p1.req_op);
          src1_q <= p1.req_src1;
          src2_q <= p1.req_src2;
          imm_q  <= p1.req_imm;
        end else begin
          op_q   <= alu_op_t'(p0.req_op);
          src1_q <= p0.req_src1;
          src2_q <= p0.req_src2;
          imm_q  <= p0.req_imm;
        end
      end
      if (state == ACTRL_EXEC) begin
        rsp_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a round-robin instance and a
// fixed-priority instance share one clock, each with its own reset.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic rst_fp;
  logic busy_rr, busy_fp;
  int   checks   = 0;
  int   failures = 0;

  alu_share_ctrl_if a0 ();
  alu_share_ctrl_if a1 ();
  alu_share_ctrl_if b0 ();
  alu_share_ctrl_if b1 ();

  alu_share_ctrl #(.FAIR_RR(1'b1)) dut_rr (
    .clk (clk), .rst (rst), .p0 (a0.slave), .p1 (a1.slave), .busy (busy_rr)
  );

  alu_share_ctrl #(.FAIR_RR(1'b0)) dut_fp (
    .clk (clk), .rst (rst_fp), .p0 (b0.slave), .p1 (b1.slave), .busy (busy_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op on the round-robin DUT from IDLE (called at a negedge);
  // returns at the negedge of the next IDLE cycle.
  task automatic issue_rr(input int port, input logic [3:0] op, input word_t s1,
                          input word_t s2, input word_t imm, input word_t exp,
                          input string tag);
    if (port == 0) begin
      a0.req_op = op; a0.req_src1 = s1; a0.req_src2 = s2; a0.req_imm = imm;
      a0.req_valid = 1'b1;
    end else begin
      a1.req_op = op; a1.req_src1 = s1; a1.req_src2 = s2; a1.req_imm = imm;
      a1.req_valid = 1'b1;
    end
    #1;
    chk({tag, "_ready"}, {30'd0, a1.req_ready, a0.req_ready}, (port == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    a0.req_valid = 1'b0; a1.req_valid = 1'b0;
    a0.req_src1 = 32'hDEAD_BEEF; a1.req_src1 = 32'hDEAD_BEEF;
    a0.req_op = 4'h2; a1.req_op = 4'h2;
    chk({tag, "_exec_busy"}, {31'd0, busy_rr}, 32'd1);
    chk({tag, "_exec_nrsp"}, {30'd0, a1.rsp_valid, a0.rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, {30'd0, a1.rsp_valid, a0.rsp_valid}, (port == 0) ? 32'd1 : 32'd2);
    chk({tag, "_data"}, (port == 0) ? a0.rsp_data : a1.rsp_data, exp);
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, busy_rr}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rst_fp = 1'b1;
    a0.req_valid = 0; a0.req_op = 0; a0.req_src1 = 0; a0.req_src2 = 0; a0.req_imm = 0; a0.rsp_ready = 1;
    a1.req_valid = 0; a1.req_op = 0; a1.req_src1 = 0; a1.req_src2 = 0; a1.req_imm = 0; a1.rsp_ready = 1;
    b0.req_valid = 0; b0.req_op = 0; b0.req_src1 = 0; b0.req_src2 = 0; b0.req_imm = 0; b0.rsp_ready = 1;
    b1.req_valid = 0; b1.req_op = 0; b1.req_src1 = 0; b1.req_src2 = 0; b1.req_imm = 0; b1.rsp_ready = 1;

    // Reset values, with a request already pending during reset.
    a0.req_op = 4'h0; a0.req_src1 = 32'd5; a0.req_src2 = 32'd7; a0.req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'd0, a0.req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy_rr}, 32'd0);
    chk("rst_rspv", {30'd0, a1.rsp_valid, a0.rsp_valid}, 32'd0);
    chk("rst_data", a0.rsp_data, 32'd0);
    chk("rst_err", {30'd0, a1.rsp_err, a0.rsp_err}, 32'd0);
    rst = 1'b0;

    issue_rr(0, 4'h0, 32'd5, 32'd7, 32'd0, 32'd12, "add");

    // Opcode coverage through port 1.
    issue_rr(1, 4'hB, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, "blt");
    issue_rr(1, 4'hD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, "bltu");
    issue_rr(1, 4'h5, 32'd1, 32'h21, 32'd0, 32'd2, "sll");
    issue_rr(1, 4'hF, 32'h100, 32'd0, 32'hFFFF_FFFC, 32'hFC, "st_addr");
    issue_rr(1, 4'h1, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, "sub_neg");
    issue_rr(1, 4'h6, 32'h8000_0000, 32'd31, 32'd0, 32'd1, "srl");
    issue_rr(1, 4'h7, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, "slt");
    issue_rr(1, 4'hC, 32'h8000_0000, 32'd0, 32'd0, 32'd0, "bge");
    issue_rr(1, 4'h9, 32'h1234, 32'h1234, 32'd0, 32'd1, "beq");
    issue_rr(1, 4'hA, 32'h1234, 32'h1234, 32'd0, 32'd0, "bne");

    // Round-robin with both ports continuously valid; last grant was port 1.
    a0.req_op = 4'h1; a0.req_src1 = 32'd10; a0.req_src2 = 32'd3; a0.req_valid = 1'b1;
    a1.req_op = 4'h4; a1.req_src1 = 32'hF0; a1.req_src2 = 32'h0F; a1.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", {30'd0, a1.req_ready, a0.req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      chk("rr_exec_ready", {30'd0, a1.req_ready, a0.req_ready}, 32'd0);
      @(negedge clk);
      chk("rr_rspv", {30'd0, a1.rsp_valid, a0.rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_data", (k % 2 == 0) ? a0.rsp_data : a1.rsp_data, (k % 2 == 0) ? 32'd7 : 32'hFF);
      @(negedge clk);
    end
    a0.req_valid = 1'b0; a1.req_valid = 1'b0;
    @(negedge clk);

    // Back-pressure on port 1 while port 0 waits.
    a1.rsp_ready = 1'b0;
    a1.req_op = 4'h2; a1.req_src1 = 32'hFF00_FF00; a1.req_src2 = 32'h0FF0_0FF0; a1.req_valid = 1'b1;
    #1;
    chk("bp_grant", {30'd0, a1.req_ready, a0.req_ready}, 32'd2);
    @(negedge clk);
    a1.req_valid = 1'b0;
    a0.req_op = 4'h0; a0.req_src1 = 32'd1; a0.req_src2 = 32'd1; a0.req_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rspv", {30'd0, a1.rsp_valid, a0.rsp_valid}, 32'd2);
      chk("bp_data", a1.rsp_data, 32'h0F00_0F00);
      chk("bp_ready", {30'd0, a1.req_ready, a0.req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy_rr}, 32'd1);
      @(negedge clk);
    end
    chk("bp_data_last", a1.rsp_data, 32'h0F00_0F00);
    a1.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", {31'd0, busy_rr}, 32'd0);
    chk("bp_release_grant", {30'd0, a1.req_ready, a0.req_ready}, 32'd1);
    @(negedge clk);
    a0.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_data", a0.rsp_data, 32'd2);
    @(negedge clk);

    // Reset during EXEC discards the operation and restores last_grant.
    a0.req_op = 4'h0; a0.req_src1 = 32'd40; a0.req_src2 = 32'd2; a0.req_valid = 1'b1;
    #1;
    chk("rx_grant", {31'd0, a0.req_ready}, 32'd1);
    @(negedge clk);
    a0.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rx_no_rsp", {30'd0, a1.rsp_valid, a0.rsp_valid}, 32'd0);
      chk("rx_busy", {31'd0, busy_rr}, 32'd0);
      @(negedge clk);
    end
    a0.req_op = 4'h0; a0.req_src1 = 32'd2; a0.req_src2 = 32'd3; a0.req_valid = 1'b1;
    a1.req_op = 4'h3; a1.req_src1 = 32'hA0; a1.req_src2 = 32'h05; a1.req_valid = 1'b1;
    #1;
    chk("rx_tie_grant", {30'd0, a1.req_ready, a0.req_ready}, 32'd1);
    @(negedge clk);
    a0.req_valid = 1'b0; a1.req_valid = 1'b0;
    @(negedge clk);
    chk("rx_tie_data", a0.rsp_data, 32'd5);
    @(negedge clk);

    // Fixed priority instance: port 0 always wins while valid.
    rst_fp = 1'b0;
    b0.req_op = 4'h1; b0.req_src1 = 32'd10; b0.req_src2 = 32'd3; b0.req_valid = 1'b1;
    b1.req_op = 4'h4; b1.req_src1 = 32'hF0; b1.req_src2 = 32'h0F; b1.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_grant", {30'd0, b1.req_ready, b0.req_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("fp_rspv", {30'd0, b1.rsp_valid, b0.rsp_valid}, 32'd1);
      chk("fp_data", b0.rsp_data, 32'd7);
      @(negedge clk);
    end
    b0.req_valid = 1'b0;
    #1;
    chk("fp_port1_grant", {30'd0, b1.req_ready, b0.req_ready}, 32'd2);
    @(negedge clk);
    b1.req_valid = 1'b0;
    @(negedge clk);
    chk("fp_port1_rspv", {30'd0, b1.rsp_valid, b0.rsp_valid}, 32'd2);
    chk("fp_port1_data", b1.rsp_data, 32'hFF);
    @(negedge clk);
    chk("fp_idle", {31'd0, busy_fp}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares the single combinational ALU between two requesters (port 0: execute stage, port 1: debug/CSR unit). It accepts one operation at a time over a valid/ready handshake and arbitrates round-robin. It registers the operands, selects the ALU output named by the opcode, and returns a registered result to the winning requester over a valid/ready response channel. It sits between the decode/issue logic and the ALU instance.

## Interface
Parameters:
- FAIR_RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N = 0,1) request present.
- reqN_ready  out  1  request accepted this cycle.
- reqN_op  in  4  opcode, `ALU_OP_*` encoding.
- reqN_src1  in  `WORD_DATA`  rs1 operand.
- reqN_src2  in  `WORD_DATA`  rs2 or immediate operand.
- reqN_imm  in  `WORD_DATA`  sign-extended store offset (store-address op only).
- rspN_valid  out  1  result pending for port N.
- rspN_ready  in  1  port N consumes result.
- rspN_data  out  `WORD_DATA`  result.
- rspN_err  out  1  reserved opcode was issued.
- busy  out  1  state != IDLE.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT, 8 SLTU.
  - 9 BEQ, A BNE, B BLT, C BGE, D BLTU, E BGEU.
  - F ST_ADDR (imm + src1).
  - No reserved opcodes in 4 bits. `ALU_OP_RSVD` is defined for future widening; rspN_err is tied low for now and kept for the interface.
- Branch ops return 32'h1 when taken, 32'h0 otherwise. SLT/SLTU return 32'h1 or 32'h0. Shifts use src2[4:0] only.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any reqN_valid, grant one port. Assert that port's reqN_ready combinationally and capture op, src1, src2, imm and owner. Update last_grant. Go to EXEC.
  - EXEC: ALU evaluates the captured operands. Register the selected result into rsp_data and raise rspN_valid for the owner. Go to RESP.
  - RESP: hold rspN_valid and rspN_data stable until rspN_ready, then go to IDLE.
- Arbitration:
  - Both valid with FAIR_RR=1: grant the port that is not last_grant.
  - Single valid: that port wins.
  - FAIR_RR=0: port 0 wins whenever valid.
- reqN_ready is low in every state except IDLE and is never asserted for both ports. reqN_ready may depend on reqN_valid. Requesters must not make valid depend on ready.
- rspM_valid for the non-owner port M stays 0.

## Timing
- Reset values: state=IDLE, last_grant=1 (port 0 wins the first tie), all rspN_valid=0, rspN_data=0, rspN_err=0, busy=0, reqN_ready=0.
- Latency: request handshake in cycle T, rspN_valid high from cycle T+2.
- Minimum issue interval is 3 cycles with rspN_ready held high. The next request is accepted in cycle T+3.
- Operands are sampled only at the handshake. Changes to reqN_* afterwards have no effect.
- Response back-pressure: stalls in RESP indefinitely. Both reqN_ready stay low. rspN_data does not change.
- rst asserted in any state: the next edge forces all reset values. An in-flight operation is discarded and no response is produced.
- Requests with valid high during reset are not accepted until the first IDLE cycle after rst deasserts.

## Structure
- The shared `global.v` gains the `ALU_OP` width macro (3:0), the `ALU_OP_*` encodings, and the FSM state encodings `ACTRL_IDLE/EXEC/RESP`. `ENABLE` and `DISABLE` are reused.
- Sub-module `alu_rr_arb2`: combinational 2-way grant from valid, last_grant and FAIR_RR, producing a one-hot grant.
- The top instantiates the existing `ALU` and an opcode-indexed result mux.

## Test plan
- Reset, then req0 ADD src1=5 src2=7 -> req0_ready at T, rsp0_valid at T+2, rsp0_data=12, rsp1_valid=0.
- Both ports valid continuously: req0 SUB 10,3 and req1 XOR F0,0F, with rsp ready held high. Grants must alternate 0,1,0,1. Data must be 7, FF, 7, FF. Accepts must be 3 cycles apart.
- FAIR_RR=0, both valid -> port 0 granted every time and port 1 is never granted. Then drop req0 -> port 1 granted on the next IDLE.
- Opcode coverage:
  - BLT on FFFFFFFF vs 1 -> 1; BLTU on the same operands -> 0.
  - SLL 1 by src2=0x21 -> 2 (uses 5 bits only).
  - ST_ADDR with imm=FFFFFFFC, src1=100 -> FC.
- Back-pressure: rsp1_ready low for 5 cycles. rsp1_valid/data held, both reqN_ready low, busy=1. Release -> IDLE next cycle.
- rst pulsed during EXEC -> no rspN_valid ever appears. The next tie goes to port 0.
